fp_product_accumulator: RTL

FP_PRODUCT_ACCUMULATOR -- requirements
Module: fp_product_accumulator

---
 rtl/fp_product_accumulator_pkg.sv | 27 ++
 rtl/fp_add_normalizer.sv | 148 ++++++++++++++
 rtl/fp_product_accumulator.sv | 112 +++++++++++
 3 files changed

// File: rtl/fp_product_accumulator_pkg.sv
// Types and constants shared by the product accumulator and its add/normalise datapath.
// Holds the IEEE-754 single field layout, the controller states and the zero test.
package fp_product_accumulator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_e;

  localparam int SIGN_W  = 1;
  localparam int EXP_W   = 8;
  localparam int MANT_W  = 23;
  localparam int FP_W    = SIGN_W + EXP_W + MANT_W;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [FP_W-1:0] POS_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] NEG_ZERO = 32'h8000_0000;

  function automatic logic fp_is_zero(input logic [FP_W-1:0] x);
    return (x == POS_ZERO) || (x == NEG_ZERO);
  endfunction

endpackage

// File: rtl/fp_add_normalizer.sv
// Three-stage single-precision adder: ALIGN and ADD take one cycle each, NORM iterates
// one left shift per cycle. The controller sequences the stages through the enables.
module fp_add_normalizer
  import fp_product_accumulator_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            align_en_i,
  input  logic            add_en_i,
  input  logic            norm_en_i,
  input  logic [FP_W-1:0] op_a_i,
  input  logic [FP_W-1:0] op_b_i,
  output logic            add_zero_o,
  output logic            norm_done_o,
  output logic [FP_W-1:0] result_o,
  output logic            result_ovf_o
);

  localparam int MAN_W  = MANT_W + 1;
  localparam int NEXP_W = EXP_W + 2;
  localparam logic signed [NEXP_W-1:0] EXP_SAT = NEXP_W'(EXP_MAX);
  localparam logic signed [NEXP_W-1:0] EXP_ONE = NEXP_W'(1);

  logic [FP_W-1:0]  op      [2];
  logic             op_sign [2];
  logic [EXP_W-1:0] op_exp  [2];
  logic             op_zero [2];
  logic [MAN_W-1:0] op_man  [2];

  assign op[0] = op_a_i;
  assign op[1] = op_b_i;

  // A zero operand contributes a zero mantissa, so the other one passes through untouched.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
      assign op_sign[gi] = op[gi][FP_W-1];
      assign op_exp[gi]  = op[gi][FP_W-2 -: EXP_W];
      assign op_zero[gi] = fp_is_zero(op[gi]);
      assign op_man[gi]  = op_zero[gi] ? '0 : {1'b1, op[gi][MANT_W-1:0]};
    end
  endgenerate

  logic             a_big;
  logic [EXP_W-1:0] exp_big, exp_diff;
  logic [MAN_W-1:0] man_small, man_shift;

  always_comb begin
    a_big     = op_zero[1] | (!op_zero[0] && (op_exp[0] >= op_exp[1]));
    exp_big   = a_big ? op_exp[0] : op_exp[1];
    exp_diff  = a_big ? (op_exp[0] - op_exp[1]) : (op_exp[1] - op_exp[0]);
    man_small = a_big ? op_man[1] : op_man[0];
    man_shift = (exp_diff >= 8'd25) ? '0 : (man_small >> exp_diff);
  end

  logic                     sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [MAN_W-1:0]         man_a_q, man_a_d, man_b_q, man_b_d;
  logic [EXP_W-1:0]         exp_q, exp_d;
  logic [MAN_W:0]           sum_q, sum_d;
  logic                     sign_q, sign_d;
  logic signed [NEXP_W-1:0] nexp_q, nexp_d;

  logic [MAN_W:0] add_sum;
  logic           add_sign;

  always_comb begin
    add_sum  = '0;
    add_sign = 1'b0;
    if (sign_a_q == sign_b_q) begin
      add_sum  = {1'b0, man_a_q} + {1'b0, man_b_q};
      add_sign = sign_a_q;
    end else if (man_a_q >= man_b_q) begin
      add_sum  = {1'b0, man_a_q - man_b_q};
      add_sign = sign_a_q;
    end else begin
      add_sum  = {1'b0, man_b_q - man_a_q};
      add_sign = sign_b_q;
    end
  end

  assign add_zero_o  = (add_sum == '0);
  assign norm_done_o = sum_q[MAN_W] | sum_q[MAN_W-1];

  logic signed [NEXP_W-1:0] norm_exp;
  logic [MANT_W-1:0]        norm_frac;

  always_comb begin
    norm_exp     = sum_q[MAN_W] ? (nexp_q + EXP_ONE) : nexp_q;
    norm_frac    = sum_q[MAN_W] ? sum_q[MAN_W-1:1] : sum_q[MANT_W-1:0];
    result_ovf_o = 1'b0;
    if (norm_exp >= EXP_SAT) begin
      result_o     = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      result_ovf_o = 1'b1;
    end else if (norm_exp < EXP_ONE) begin
      result_o = POS_ZERO;
    end else begin
      result_o = {sign_q, norm_exp[EXP_W-1:0], norm_frac};
    end
  end

  always_comb begin
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    man_a_d  = man_a_q;
    man_b_d  = man_b_q;
    exp_d    = exp_q;
    sum_d    = sum_q;
    sign_d   = sign_q;
    nexp_d   = nexp_q;
    if (align_en_i) begin
      sign_a_d = op_sign[0];
      sign_b_d = op_sign[1];
      man_a_d  = a_big ? op_man[0] : man_shift;
      man_b_d  = a_big ? man_shift : op_man[1];
      exp_d    = exp_big;
    end
    if (add_en_i) begin
      sum_d  = add_sum;
      sign_d = add_sign;
      nexp_d = signed'({2'b00, exp_q});
    end else if (norm_en_i && !norm_done_o) begin
      sum_d  = {sum_q[MAN_W-1:0], 1'b0};
      nexp_d = nexp_q - EXP_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      man_a_q  <= '0;
      man_b_q  <= '0;
      exp_q    <= '0;
      sum_q    <= '0;
      sign_q   <= 1'b0;
      nexp_q   <= '0;
    end else begin
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      man_a_q  <= man_a_d;
      man_b_q  <= man_b_d;
      exp_q    <= exp_d;
      sum_q    <= sum_d;
      sign_q   <= sign_d;
      nexp_q   <= nexp_d;
    end
  end

endmodule

// File: rtl/fp_product_accumulator.sv
// Sums a stream of single-precision products one term at a time and hands the total,
// term count and sticky overflow to the consumer with a valid/ready handshake.
module fp_product_accumulator
  import fp_product_accumulator_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [FP_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             in_overflow,
  output logic             in_ready,
  output logic [FP_W-1:0]  out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  state_e            state_q;
  logic [FP_W-1:0]   acc_q, term_q;
  logic [CNT_W-1:0]  count_q;
  logic              last_q, sticky_q, in_ready_q, out_valid_q;

  logic              dp_add_zero, dp_norm_done, dp_result_ovf;
  logic [FP_W-1:0]   dp_result;

  fp_add_normalizer u_dp (
    .clk          (clk),
    .rst          (rst),
    .align_en_i   (state_q == ALIGN),
    .add_en_i     (state_q == ADD),
    .norm_en_i    (state_q == NORM),
    .op_a_i       (acc_q),
    .op_b_i       (term_q),
    .add_zero_o   (dp_add_zero),
    .norm_done_o  (dp_norm_done),
    .result_o     (dp_result),
    .result_ovf_o (dp_result_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= POS_ZERO;
      term_q      <= POS_ZERO;
      count_q     <= '0;
      last_q      <= 1'b0;
      sticky_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            term_q     <= in_data;
            last_q     <= in_last;
            sticky_q   <= sticky_q | in_overflow;
            count_q    <= count_q + CNT_W'(1);
            in_ready_q <= 1'b0;
            state_q    <= ALIGN;
          end
        end
        ALIGN: state_q <= ADD;
        // A zero sum is already normalised, so NORM is bypassed.
        ADD: begin
          if (dp_add_zero) begin
            acc_q       <= POS_ZERO;
            state_q     <= last_q ? DONE : IDLE;
            in_ready_q  <= !last_q;
            out_valid_q <= last_q;
          end else begin
            state_q <= NORM;
          end
        end
        NORM: begin
          if (dp_norm_done) begin
            acc_q       <= dp_result;
            sticky_q    <= sticky_q | dp_result_ovf;
            state_q     <= last_q ? DONE : IDLE;
            in_ready_q  <= !last_q;
            out_valid_q <= last_q;
          end
        end
        DONE: begin
          if (out_ready) begin
            acc_q       <= POS_ZERO;
            count_q     <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_sum      = acc_q;
  assign out_count    = count_q;
  assign out_overflow = sticky_q;

endmodule
